ex_muldiv_ctrl: RTL

Sequencing controller for multiply/divide instructions in the EX stage. It sits beside the single-cycle ALU and is enabled when the EX control word flags a MUL-class instruction (`CAL_MUL`). It captures the forwarded operands, runs a two-cycle multiply pipeline or a 32-iteration restoring divider, and holds the front of the pipeline with `stall_out` until the result is ready. On the release cycle it returns the 32-bit result to the EX result mux.

---
 rtl/ex_muldiv_ctrl_if.sv | 32 +++
 rtl/ex_muldiv_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl_if.sv
// ============================================================================
// Module   : ex_muldiv_ctrl_if
// Brief    : EX-stage mul/div request and result bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_muldiv_ctrl_if #(
    parameter int WORD = 32
) ();
    logic            req_valid;
    logic [2:0]      req_op;
    logic [WORD-1:0] src_a;
    logic [WORD-1:0] src_b;
    logic            flush;
    logic            stall_out;
    logic            res_valid;
    logic [WORD-1:0] result;
    logic            busy;

    modport master (
        output req_valid, req_op, src_a, src_b, flush,
        input  stall_out, res_valid, result, busy
    );

    modport slave (
        input  req_valid, req_op, src_a, src_b, flush,
        output stall_out, res_valid, result, busy
    );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_ctrl.sv
// ============================================================================
// Module   : ex_muldiv_ctrl
// Brief    : EX-stage multiply (2-cycle) / restoring divide (32-step) sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_ctrl #(
    parameter int WORD = 32
) (
    input  logic             clk,
    input  logic             rst,
    ex_muldiv_ctrl_if.slave  bus
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_MUL1 = 3'd1;
    localparam logic [2:0] c_MUL2 = 3'd2;
    localparam logic [2:0] c_DIV  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [4:0] c_LAST_STEP = 5'd31;

    logic [2:0]        r_state;
    logic [1:0]        r_op;
    logic [WORD-1:0]   r_a;
    logic [WORD-1:0]   r_b;
    logic [2*WORD-1:0] r_prod;
    logic [WORD-1:0]   r_quo;
    logic [WORD-1:0]   r_rem;
    logic [WORD-1:0]   r_div;
    logic              r_q_neg;
    logic              r_r_neg;
    logic [4:0]        r_count;
    logic [WORD-1:0]   r_result;

    // Operand magnitudes for signed divides, taken straight off the forwarded buses.
    logic            w_signed_div;
    logic [WORD-1:0] w_a_mag;
    logic [WORD-1:0] w_b_mag;

    assign w_signed_div = ~bus.req_op[1];
    assign w_a_mag = (w_signed_div & bus.src_a[WORD-1]) ? -bus.src_a : bus.src_a;
    assign w_b_mag = (w_signed_div & bus.src_b[WORD-1]) ? -bus.src_b : bus.src_b;

    // Operands are fully extended to 64 bits, so the low 64 product bits are exact.
    logic              w_mul_zext;
    logic              w_mul_hi;
    logic [2*WORD-1:0] w_mul_a;
    logic [2*WORD-1:0] w_mul_b;
    logic [2*WORD-1:0] w_prod;

    assign w_mul_zext = (r_op == 2'b10);
    assign w_mul_hi   = (r_op == 2'b01) | (r_op == 2'b10);
    assign w_mul_a    = {{WORD{~w_mul_zext & r_a[WORD-1]}}, r_a};
    assign w_mul_b    = {{WORD{~w_mul_zext & r_b[WORD-1]}}, r_b};
    assign w_prod     = w_mul_a * w_mul_b;

    // One restoring step; the dividend is shifted out of r_quo as quotient bits shift in.
    logic [WORD:0]   w_rem_sh;
    logic            w_ge;
    logic [WORD-1:0] w_sub;
    logic [WORD-1:0] w_rem_nx;
    logic [WORD-1:0] w_quo_nx;
    logic [WORD-1:0] w_div_res;

    assign w_rem_sh = {r_rem, r_quo[WORD-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div});
    assign w_sub    = w_rem_sh[WORD-1:0] - r_div;
    assign w_rem_nx = w_ge ? w_sub : w_rem_sh[WORD-1:0];
    assign w_quo_nx = {r_quo[WORD-2:0], w_ge};
    assign w_div_res = r_op[0] ? (r_r_neg ? -w_rem_nx : w_rem_nx)
                               : (r_q_neg ? -w_quo_nx : w_quo_nx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_op     <= 2'b00;
            r_a      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_count  <= 5'd0;
            r_result <= '0;
        end else if (bus.flush) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= bus.req_op[1:0];
                        r_a     <= bus.src_a;
                        r_b     <= bus.src_b;
                        r_quo   <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_rem   <= '0;
                        r_count <= 5'd0;
                        r_q_neg <= w_signed_div & (bus.src_a[WORD-1] ^ bus.src_b[WORD-1]);
                        r_r_neg <= w_signed_div & bus.src_a[WORD-1];
                        if (!bus.req_op[2]) begin
                            r_state <= c_MUL1;
                        end else if (bus.src_b == '0) begin
                            r_state  <= c_DONE;
                            r_result <= bus.req_op[0] ? bus.src_a : '1;
                        end else begin
                            r_state <= c_DIV;
                        end
                    end
                end
                c_MUL1: begin
                    r_prod  <= w_prod;
                    r_state <= c_MUL2;
                end
                c_MUL2: begin
                    r_result <= w_mul_hi ? r_prod[2*WORD-1:WORD] : r_prod[WORD-1:0];
                    r_state  <= c_DONE;
                end
                c_DIV: begin
                    r_quo   <= w_quo_nx;
                    r_rem   <= w_rem_nx;
                    r_count <= r_count + 5'd1;
                    if (r_count == c_LAST_STEP) begin
                        r_result <= w_div_res;
                        r_state  <= c_DONE;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.stall_out = bus.req_valid & (r_state != c_DONE) & ~bus.flush & ~rst;
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.res_valid = (r_state == c_DONE);
    assign bus.result    = r_result;

endmodule

`default_nettype wire
